// File: rtl/bahis_kuyrugu.sv
// Bet-entry stage for the derby betting block: validates incoming tickets,
// buffers them in a small FIFO and hands out one bet per derby per session.
module bahis_kuyrugu #(
    parameter int DERIN        = 4,
    parameter int DERBI_SAYISI = 10,
    parameter int MAX_PARA     = 100
) (
    input  logic                     saat,
    input  logic                     reset,
    input  logic                     yeni_oturum,
    input  logic                     giris_gecerli,
    output logic                     giris_hazir,
    input  logic [1:0]               giris_at,
    input  logic [6:0]               giris_para,
    output logic                     cikis_gecerli,
    input  logic                     cikis_al,
    output logic [1:0]               cikis_at,
    output logic [6:0]               cikis_para,
    output logic [$clog2(DERIN):0]   doluluk,
    output logic [3:0]               red_sayac,
    output logic [3:0]               derbi_sayac,
    output logic                     bitti
);

    localparam int AW = $clog2(DERIN);

    // Horse code 3 is unused; stake must be non-zero and within the table limit.
    function automatic logic bilet_gecerli(input logic [1:0] at, input logic [6:0] para);
        return (at != 2'd3) && (para != 7'd0) && (para <= 7'(MAX_PARA));
    endfunction

    logic [8:0]    mem_q [DERIN];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   doluluk_q, doluluk_d;
    logic [3:0]    red_q, red_d;
    logic [3:0]    derbi_q, derbi_d;
    logic          bitti_q, bitti_d;
    logic          dolu_s, push_s, pop_s, kabul_s;

    assign dolu_s        = (doluluk_q == (AW+1)'(DERIN));
    assign giris_hazir   = reset && !dolu_s && !bitti_q && !yeni_oturum;
    assign cikis_gecerli = (doluluk_q != '0) && !bitti_q;
    assign cikis_at      = (doluluk_q != '0) ? mem_q[rd_ptr_q][8:7] : 2'd0;
    assign cikis_para    = (doluluk_q != '0) ? mem_q[rd_ptr_q][6:0] : 7'd0;
    assign doluluk       = doluluk_q;
    assign red_sayac     = red_q;
    assign derbi_sayac   = derbi_q;
    assign bitti         = bitti_q;

    assign push_s  = giris_gecerli && giris_hazir;
    assign pop_s   = cikis_gecerli && cikis_al;
    assign kabul_s = push_s && bilet_gecerli(giris_at, giris_para);

    // Next-state for pointers, occupancy and session counters; a session clear wins over any transfer.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        doluluk_d = doluluk_q;
        red_d     = red_q;
        derbi_d   = derbi_q;
        bitti_d   = bitti_q;
        if (yeni_oturum) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            doluluk_d = '0;
            red_d     = 4'd0;
            derbi_d   = 4'd0;
            bitti_d   = 1'b0;
        end else begin
            if (kabul_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (push_s && !kabul_s && (red_q != 4'hF)) begin
                red_d = red_q + 4'd1;
            end else begin
                red_d = red_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
                derbi_d  = derbi_q + 4'd1;
                bitti_d  = ((derbi_q + 4'd1) == 4'(DERBI_SAYISI));
            end else begin
                rd_ptr_d = rd_ptr_q;
                derbi_d  = derbi_q;
                bitti_d  = bitti_q;
            end
            case ({kabul_s, pop_s})
                2'b10:   doluluk_d = doluluk_q + (AW+1)'(1'b1);
                2'b01:   doluluk_d = doluluk_q - (AW+1)'(1'b1);
                default: doluluk_d = doluluk_q;
            endcase
        end
    end

    // State registers and ticket storage; storage is cleared on reset so the head is never X.
    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            doluluk_q <= '0;
            red_q     <= 4'd0;
            derbi_q   <= 4'd0;
            bitti_q   <= 1'b0;
            for (int i = 0; i < DERIN; i++) begin
                mem_q[i] <= 9'd0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            doluluk_q <= doluluk_d;
            red_q     <= red_d;
            derbi_q   <= derbi_d;
            bitti_q   <= bitti_d;
            if (kabul_s) begin
                mem_q[wr_ptr_q] <= {giris_at, giris_para};
            end
        end
    end

endmodule

// File: tb/tb_bahis_kuyrugu.sv
// Scoreboard bench for bahis_kuyrugu: a reference queue model tracks accepted
// tickets, session counters and lock state; every cycle the DUT is compared to it.
module tb_bahis_kuyrugu;

    logic       saat = 1'b0;
    logic       reset = 1'b0;
    logic       yeni_oturum = 1'b0;
    logic       giris_gecerli = 1'b0;
    logic       giris_hazir;
    logic [1:0] giris_at = 2'd0;
    logic [6:0] giris_para = 7'd0;
    logic       cikis_gecerli;
    logic       cikis_al = 1'b0;
    logic [1:0] cikis_at;
    logic [6:0] cikis_para;
    logic [2:0] doluluk;
    logic [3:0] red_sayac;
    logic [3:0] derbi_sayac;
    logic       bitti;

    int gecen = 0;
    int toplam = 0;

    logic [8:0] sb_q[$];
    int  m_red = 0;
    int  m_derbi = 0;
    bit  m_bitti = 1'b0;

    bahis_kuyrugu #(.DERIN(4), .DERBI_SAYISI(10), .MAX_PARA(100)) dut (
        .saat(saat), .reset(reset), .yeni_oturum(yeni_oturum),
        .giris_gecerli(giris_gecerli), .giris_hazir(giris_hazir),
        .giris_at(giris_at), .giris_para(giris_para),
        .cikis_gecerli(cikis_gecerli), .cikis_al(cikis_al),
        .cikis_at(cikis_at), .cikis_para(cikis_para),
        .doluluk(doluluk), .red_sayac(red_sayac),
        .derbi_sayac(derbi_sayac), .bitti(bitti)
    );

    always #5 saat = ~saat;

    task automatic kontrol_et(input string etiket, input int gozlenen, input int beklenen);
        toplam++;
        if (gozlenen == beklenen) begin
            gecen++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", etiket, gozlenen, beklenen, $time);
        end
    endtask

    function automatic bit m_hazir();
        return reset && (sb_q.size() < 4) && !m_bitti && !yeni_oturum;
    endfunction

    function automatic bit m_cgecerli();
        return (sb_q.size() != 0) && !m_bitti;
    endfunction

    task automatic hepsini_karsilastir();
        kontrol_et("giris_hazir", int'(giris_hazir), int'(m_hazir()));
        kontrol_et("cikis_gecerli", int'(cikis_gecerli), int'(m_cgecerli()));
        kontrol_et("doluluk", int'(doluluk), sb_q.size());
        kontrol_et("red_sayac", int'(red_sayac), m_red);
        kontrol_et("derbi_sayac", int'(derbi_sayac), m_derbi);
        kontrol_et("bitti", int'(bitti), int'(m_bitti));
        kontrol_et("cikis_at", int'(cikis_at), (sb_q.size() != 0) ? int'(sb_q[0][8:7]) : 0);
        kontrol_et("cikis_para", int'(cikis_para), (sb_q.size() != 0) ? int'(sb_q[0][6:0]) : 0);
    endtask

    // One clock cycle: drive at negedge, compare, then advance the model at the posedge.
    task automatic adim(input bit gec, input int at, input int para, input bit al, input bit yeni);
        bit push, pop, gecerli_bilet;
        giris_gecerli = gec;
        giris_at      = 2'(at);
        giris_para    = 7'(para);
        cikis_al      = al;
        yeni_oturum   = yeni;
        #1;
        hepsini_karsilastir();
        push = gec && m_hazir();
        pop  = al && m_cgecerli();
        gecerli_bilet = (at >= 0) && (at <= 2) && (para >= 1) && (para <= 100);
        @(posedge saat);
        if (yeni) begin
            sb_q.delete();
            m_red = 0;
            m_derbi = 0;
            m_bitti = 1'b0;
        end else begin
            if (pop) begin
                void'(sb_q.pop_front());
                m_derbi++;
                if (m_derbi == 10) m_bitti = 1'b1;
            end
            if (push) begin
                if (gecerli_bilet) sb_q.push_back({2'(at), 7'(para)});
                else if (m_red < 15) m_red++;
            end
        end
        @(negedge saat);
    endtask

    task automatic bosta();
        adim(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        @(negedge saat);
        #1;
        hepsini_karsilastir();
        @(negedge saat);
        reset = 1'b1;

        // Three pushes, then fill to four, hold off a fifth until one pop frees a slot.
        adim(1'b1, 1, 20, 1'b0, 1'b0);
        adim(1'b1, 2, 5, 1'b0, 1'b0);
        adim(1'b1, 0, 100, 1'b0, 1'b0);
        adim(1'b1, 1, 1, 1'b0, 1'b0);
        adim(1'b1, 2, 77, 1'b0, 1'b0);
        adim(1'b1, 2, 77, 1'b1, 1'b0);
        adim(1'b1, 2, 77, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) adim(1'b0, 0, 0, 1'b1, 1'b0);
        adim(1'b0, 0, 0, 1'b1, 1'b0);

        // Invalid tickets, then saturation of the reject counter.
        adim(1'b0, 0, 0, 1'b0, 1'b1);
        adim(1'b1, 3, 10, 1'b0, 1'b0);
        adim(1'b1, 0, 0, 1'b0, 1'b0);
        adim(1'b1, 1, 101, 1'b0, 1'b0);
        adim(1'b1, 2, 127, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) adim(1'b1, 3, i + 1, 1'b0, 1'b0);
        adim(1'b1, 0, 0, 1'b0, 1'b0);
        bosta();

        // Session limit: stream twelve tickets with the consumer always taking.
        adim(1'b0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) adim(1'b1, i % 3, 10 + i, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) adim(1'b1, 1, 50, 1'b1, 1'b0);

        // Session clear overriding a simultaneous push and pop.
        adim(1'b0, 0, 0, 1'b0, 1'b1);
        adim(1'b1, 1, 30, 1'b0, 1'b0);
        adim(1'b1, 2, 31, 1'b0, 1'b0);
        adim(1'b1, 0, 32, 1'b1, 1'b1);
        adim(1'b1, 2, 33, 1'b0, 1'b0);
        adim(1'b0, 0, 0, 1'b1, 1'b0);

        // Build doluluk=3 / derbi_sayac=5, then async reset between edges.
        adim(1'b0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) adim(1'b1, 1, 40 + i, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) adim(1'b1, 2, 60 + i, 1'b1, 1'b0);
        #1;
        hepsini_karsilastir();
        #1;
        reset = 1'b0;
        sb_q.delete();
        m_red = 0;
        m_derbi = 0;
        m_bitti = 1'b0;
        #1;
        hepsini_karsilastir();
        @(negedge saat);
        reset = 1'b1;
        adim(1'b1, 0, 9, 1'b1, 1'b0);
        adim(1'b1, 1, 8, 1'b1, 1'b0);
        adim(1'b0, 0, 0, 1'b1, 1'b0);
        bosta();

        // Random traffic against the model, with rare session clears.
        for (int i = 0; i < 300; i++) begin
            adim(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 127)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0));
        end
        bosta();

        $display("%0d/%0d checks passed", gecen, toplam);
        $finish;
    end

endmodule
